// File: rtl/rca_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_bist_pkg
// Description : Shared state encoding and sizing helpers for the RCA BIST.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_bist_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_APPLY = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
   localparam logic [STATE_W-1:0] ST_CHECK = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   // Vector index packs {Carry_in, x, y}.
   function automatic int idx_width(input int width);
      return 2 * width + 1;
   endfunction

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rca_bist_cmp.sv
`default_nettype none
// ============================================================================
// Module      : rca_bist_cmp
// Description : Golden W+1-bit add and compare against the adder under test.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_bist_cmp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             Carry_in,
   input  logic [WIDTH-1:0] s,
   input  logic             Carry_out,
   output logic             mismatch
);

   logic [WIDTH:0] w_golden;

   assign w_golden = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, Carry_in};
   assign mismatch = ({Carry_out, s} != w_golden);

endmodule
`default_nettype wire

// File: rtl/rca_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rca_bist_ctrl
// Description : Exhaustive self-test sweep of a ripple-carry adder stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_bist_ctrl
   import rca_bist_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = 1,
   parameter int ERR_W      = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [WIDTH-1:0]      x,
   output logic [WIDTH-1:0]      y,
   output logic                  Carry_in,
   input  logic [WIDTH-1:0]      s,
   input  logic                  Carry_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_cnt,
   output logic                  err_pulse,
   output logic [2*WIDTH:0]      first_err_idx
);

   localparam int IDX_W = idx_width(WIDTH);
   localparam int CNT_W = (clog2(SETTLE_CYC) < 1) ? 1 : clog2(SETTLE_CYC);

   localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [ERR_W-1:0] C_ERR_MAX     = '1;
   localparam logic [IDX_W-1:0] C_IDX_LAST    = '1;

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [CNT_W-1:0]   r_settle;
   logic [ERR_W-1:0]   r_err_cnt;
   logic [IDX_W-1:0]   r_first_err;
   logic               w_mismatch;
   logic               w_start_ok;
   logic               w_check;

   assign Carry_in      = r_idx[IDX_W-1];
   assign x             = r_idx[IDX_W-2:WIDTH];
   assign y             = r_idx[WIDTH-1:0];
   assign err_cnt       = r_err_cnt;
   assign first_err_idx = r_first_err;

   assign w_start_ok = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !abort;
   // Abort pre-empts the compare so a half-finished vector is never scored.
   assign w_check    = (r_state == ST_CHECK) && !abort;

   rca_bist_cmp #(
      .WIDTH(WIDTH)
   ) u_cmp (
      .x        (x),
      .y        (y),
      .Carry_in (Carry_in),
      .s        (s),
      .Carry_out(Carry_out),
      .mismatch (w_mismatch)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (w_start_ok) w_state_nxt = ST_APPLY;
         ST_APPLY:         w_state_nxt = abort ? ST_IDLE : ST_WAIT;
         ST_WAIT: begin
            if (abort)              w_state_nxt = ST_IDLE;
            else if (r_settle == '0) w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (abort)                    w_state_nxt = ST_IDLE;
            else if (r_idx == C_IDX_LAST) w_state_nxt = ST_DONE;
            else                          w_state_nxt = ST_APPLY;
         end
         default:          w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state == ST_APPLY) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
      done      = (r_state == ST_DONE);
      pass      = (r_state == ST_DONE) && (r_err_cnt == '0);
      err_pulse = w_check && w_mismatch;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx       <= '0;
         r_settle    <= '0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
      end else if (w_start_ok) begin
         r_idx       <= '0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
      end else begin
         if (r_state == ST_APPLY) begin
            r_settle <= C_SETTLE_LOAD;
         end
         if ((r_state == ST_WAIT) && (r_settle != '0)) begin
            r_settle <= r_settle - CNT_W'(1);
         end
         if (w_check) begin
            if (w_mismatch) begin
               if (r_err_cnt != C_ERR_MAX) r_err_cnt <= r_err_cnt + ERR_W'(1);
               if (r_err_cnt == '0)        r_first_err <= r_idx;
            end
            // idx parks at all-ones in DONE.
            if (r_idx != C_IDX_LAST) r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

endmodule
`default_nettype wire
